// File: rtl/hud_sequencer.sv
// ============================================================================
// Module   : hud_sequencer
// Brief    : Frame-driven HUD layer sequencer. Tracks stage and 3-digit BCD
//            score and runs a banner / blink / play state machine that gates
//            the stage, score and digit text layers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hud_sequencer #(
    parameter int BANNER_FRAMES = 120,
    parameter int BLINK_FRAMES  = 64,
    parameter int BLINK_HALF    = 8,
    parameter int MAX_STAGE     = 9
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        newGame,
    input  logic        newStage,
    input  logic        scoreAdd,
    input  logic [2:0]  scorePoints,
    output logic        stageTextEn,
    output logic        scoreTextEn,
    output logic        digitsEn,
    output logic [3:0]  stageDigit,
    output logic [11:0] scoreBCD,
    output logic        hudBusy
);

    localparam int CNT_MAX = (BANNER_FRAMES > BLINK_FRAMES) ? BANNER_FRAMES : BLINK_FRAMES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int HW      = $clog2(BLINK_HALF + 1);

    localparam logic [CW-1:0] C_BANNER = CW'(BANNER_FRAMES);
    localparam logic [CW-1:0] C_BLINK  = CW'(BLINK_FRAMES);
    localparam logic [HW-1:0] C_HALF   = HW'(BLINK_HALF);
    localparam logic [3:0]    C_MAXSTG = 4'(MAX_STAGE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BANNER = 2'd1,
        S_BLINK  = 2'd2,
        S_PLAY   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    stage_q, stage_d;
    logic [11:0]   score_q, score_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] half_q, half_d;
    logic          blink_q, blink_d;
    logic          stage_en_q, score_en_q, digits_en_q, busy_q;
    logic          stage_en_d, score_en_d, digits_en_d, busy_d;

    logic [11:0]   score_sum;
    logic [CW-1:0] cnt_inc;
    logic [HW-1:0] half_inc;

    assign cnt_inc  = cnt_q + CW'(1);
    assign half_inc = half_q + HW'(1);

    // Single-cycle BCD addition of scorePoints with ripple carry, saturating at 999
    always_comb begin
        logic [4:0] u_sum, t_sum, h_sum;
        logic       c_u, c_t;
        score_sum = score_q;
        u_sum = {1'b0, score_q[3:0]} + {2'b00, scorePoints};
        c_u   = (u_sum > 5'd9);
        if (c_u) u_sum = u_sum - 5'd10;
        t_sum = {1'b0, score_q[7:4]} + {4'b0000, c_u};
        c_t   = (t_sum > 5'd9);
        if (c_t) t_sum = t_sum - 5'd10;
        h_sum = {1'b0, score_q[11:8]} + {4'b0000, c_t};
        if (h_sum > 5'd9) score_sum = 12'h999;
        else              score_sum = {h_sum[3:0], t_sum[3:0], u_sum[3:0]};
    end

    // Next-state logic: restart events first, then score and frame handling
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        score_d = score_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        blink_d = blink_q;

        if (newGame) begin
            state_d = S_BANNER;
            stage_d = 4'd1;
            score_d = 12'h000;
            cnt_d   = '0;
            half_d  = '0;
            blink_d = 1'b1;
        end else if (newStage && (state_q != S_IDLE)) begin
            state_d = S_BANNER;
            stage_d = (stage_q >= C_MAXSTG) ? C_MAXSTG : stage_q + 4'd1;
            cnt_d   = '0;
            half_d  = '0;
            blink_d = 1'b1;
            if (scoreAdd) score_d = score_sum;
        end else begin
            if (scoreAdd && (state_q != S_IDLE)) score_d = score_sum;
            if (startOfFrame) begin
                case (state_q)
                    S_BANNER: begin
                        if (cnt_inc == C_BANNER) begin
                            state_d = S_BLINK;
                            cnt_d   = '0;
                            half_d  = '0;
                            blink_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    S_BLINK: begin
                        if (cnt_inc == C_BLINK) begin
                            state_d = S_PLAY;
                            cnt_d   = '0;
                            half_d  = '0;
                            blink_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                            // Half-period counter runs from BLINK entry
                            if (half_inc == C_HALF) begin
                                half_d  = '0;
                                blink_d = ~blink_q;
                            end else begin
                                half_d = half_inc;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        stage_en_d  = (state_d == S_BANNER) || ((state_d == S_BLINK) && blink_d);
        digits_en_d = (state_d == S_BANNER) || (state_d == S_PLAY) ||
                      ((state_d == S_BLINK) && blink_d);
        score_en_d  = (state_d == S_PLAY);
        busy_d      = (state_d == S_BANNER) || (state_d == S_BLINK);
    end

    // State, datapath and registered layer enables
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_IDLE;
            stage_q     <= 4'd0;
            score_q     <= 12'h000;
            cnt_q       <= '0;
            half_q      <= '0;
            blink_q     <= 1'b1;
            stage_en_q  <= 1'b0;
            score_en_q  <= 1'b0;
            digits_en_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            score_q     <= score_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            blink_q     <= blink_d;
            stage_en_q  <= stage_en_d;
            score_en_q  <= score_en_d;
            digits_en_q <= digits_en_d;
            busy_q      <= busy_d;
        end
    end

    assign stageTextEn = stage_en_q;
    assign scoreTextEn = score_en_q;
    assign digitsEn    = digits_en_q;
    assign stageDigit  = stage_q;
    assign scoreBCD    = score_q;
    assign hudBusy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_hud_sequencer.sv
// ============================================================================
// Module   : tb_hud_sequencer
// Brief    : Scoreboard bench for hud_sequencer with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hud_sequencer;

    logic        clk;
    logic        resetN;
    logic        startOfFrame, newGame, newStage, scoreAdd;
    logic [2:0]  scorePoints;
    logic        stageTextEn, scoreTextEn, digitsEn, hudBusy;
    logic [3:0]  stageDigit;
    logic [11:0] scoreBCD;

    int n_cmp = 0;
    int n_err = 0;

    string       name_q[$];
    logic [19:0] val_q[$];

    hud_sequencer #(
        .BANNER_FRAMES(4),
        .BLINK_FRAMES (4),
        .BLINK_HALF   (2),
        .MAX_STAGE    (3)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .newGame     (newGame),
        .newStage    (newStage),
        .scoreAdd    (scoreAdd),
        .scorePoints (scorePoints),
        .stageTextEn (stageTextEn),
        .scoreTextEn (scoreTextEn),
        .digitsEn    (digitsEn),
        .stageDigit  (stageDigit),
        .scoreBCD    (scoreBCD),
        .hudBusy     (hudBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector layout: {stageTextEn, scoreTextEn, digitsEn, hudBusy, stage, score}
    function automatic logic [19:0] E(logic st, logic sc, logic dg, logic bz,
                                      logic [3:0] sg, logic [11:0] s);
        return {st, sc, dg, bz, sg, s};
    endfunction
    function automatic logic [19:0] BN(logic [3:0] sg, logic [11:0] s);
        return E(1'b1, 1'b0, 1'b1, 1'b1, sg, s);
    endfunction
    function automatic logic [19:0] BL(logic ph, logic [3:0] sg, logic [11:0] s);
        return E(ph, 1'b0, ph, 1'b1, sg, s);
    endfunction
    function automatic logic [19:0] PL(logic [3:0] sg, logic [11:0] s);
        return E(1'b0, 1'b1, 1'b1, 1'b0, sg, s);
    endfunction
    localparam logic [19:0] ID = 20'h00000;

    // Monitor: pops one expectation per cycle and compares against the outputs
    initial begin
        string       nm;
        logic [19:0] ev, got;
        forever begin
            @(negedge clk);
            if (val_q.size() > 0) begin
                nm  = name_q.pop_front();
                ev  = val_q.pop_front();
                got = {stageTextEn, scoreTextEn, digitsEn, hudBusy, stageDigit, scoreBCD};
                n_cmp++;
                if (got !== ev) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h", nm, got, ev);
                end
            end
        end
    end

    task automatic push_exp(input string nm, input logic [19:0] ev);
        name_q.push_back(nm);
        val_q.push_back(ev);
    endtask

    // Drive one cycle of inputs; optionally queue the expected response
    task automatic step(input logic sof, input logic ng, input logic ns, input logic sa,
                        input logic [2:0] pts, input bit chk, input string nm,
                        input logic [19:0] ev);
        startOfFrame = sof;
        newGame      = ng;
        newStage     = ns;
        scoreAdd     = sa;
        scorePoints  = pts;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        newGame      = 1'b0;
        newStage     = 1'b0;
        scoreAdd     = 1'b0;
        scorePoints  = 3'd0;
        if (chk) push_exp(nm, ev);
        @(negedge clk);
    endtask

    initial begin
        resetN = 1'b0;
        startOfFrame = 1'b0; newGame = 1'b0; newStage = 1'b0;
        scoreAdd = 1'b0; scorePoints = 3'd0;
        @(posedge clk); #1;
        push_exp("reset", ID);
        @(negedge clk);
        resetN = 1'b1;

        step(0,0,0,0,0, 1, "idle", ID);
        step(0,1,0,0,0, 1, "newgame", BN(1, 12'h000));
        for (int i = 0; i < 3; i++) step(1,0,0,0,0, 1, "banner_hold", BN(1, 12'h000));
        step(1,0,0,0,0, 1, "to_blink", BL(1, 1, 12'h000));
        step(1,0,0,0,0, 1, "blink1", BL(1, 1, 12'h000));
        step(1,0,0,0,0, 1, "blink2", BL(0, 1, 12'h000));
        step(1,0,0,0,0, 1, "blink3", BL(0, 1, 12'h000));
        step(1,0,0,0,0, 1, "to_play", PL(1, 12'h000));

        for (int i = 0; i < 13; i++) step(0,0,0,1,7, 0, "", ID);
        step(0,0,0,1,7, 1, "score098", PL(1, 12'h098));
        step(0,0,0,1,5, 1, "score103", PL(1, 12'h103));
        step(0,0,0,1,0, 1, "add_zero", PL(1, 12'h103));

        step(0,0,1,0,0, 1, "ns1", BN(2, 12'h103));
        for (int i = 0; i < 3; i++) step(1,0,0,0,0, 0, "", ID);
        step(0,0,1,0,0, 1, "ns2", BN(3, 12'h103));
        for (int i = 0; i < 3; i++) step(1,0,0,0,0, 1, "ns_clear", BN(3, 12'h103));
        step(0,0,1,0,0, 1, "ns3", BN(3, 12'h103));
        step(0,0,1,0,0, 1, "ns4", BN(3, 12'h103));
        for (int i = 0; i < 3; i++) step(1,0,0,0,0, 0, "", ID);
        step(1,0,1,0,0, 1, "sof_ns", BN(3, 12'h103));
        for (int i = 0; i < 3; i++) step(1,0,0,0,0, 1, "sof_ns_hold", BN(3, 12'h103));
        step(1,0,0,0,0, 1, "blink_after_clear", BL(1, 3, 12'h103));

        step(0,1,0,0,0, 1, "ng2", BN(1, 12'h000));
        for (int i = 0; i < 142; i++) step(0,0,0,1,7, 0, "", ID);
        step(0,0,0,1,3, 1, "score997", BN(1, 12'h997));
        step(0,0,0,1,7, 1, "sat999", BN(1, 12'h999));
        step(0,0,0,1,7, 1, "sat_hold", BN(1, 12'h999));
        step(0,0,0,1,1, 1, "sat_hold1", BN(1, 12'h999));

        step(0,1,0,0,0, 1, "ng3", BN(1, 12'h000));
        step(0,0,0,1,7, 0, "", ID);
        step(0,0,0,1,3, 1, "score010", BN(1, 12'h010));
        step(0,0,1,1,3, 1, "ns_add", BN(2, 12'h013));
        step(0,1,0,1,5, 1, "ng_add", BN(1, 12'h000));

        for (int i = 0; i < 3; i++) step(1,0,0,0,0, 0, "", ID);
        step(1,0,0,0,0, 1, "blink_pre_reset", BL(1, 1, 12'h000));
        step(1,0,0,0,0, 1, "blink_pre_reset1", BL(1, 1, 12'h000));

        // Assert reset between clock edges; outputs must clear before the next edge
        @(posedge clk); #2;
        resetN = 1'b0;
        push_exp("async_reset", ID);
        @(negedge clk);
        resetN = 1'b1;

        step(0,0,0,1,5, 1, "idle_add", ID);
        step(0,0,1,0,0, 1, "idle_ns", ID);
        step(1,0,0,0,0, 1, "idle_sof", ID);
        step(0,1,0,0,0, 1, "restart", BN(1, 12'h000));

        @(negedge clk);
        @(negedge clk);
        if (val_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", val_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
